// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants: index width default and entry-kind encodings.
package reorder_buffer_pkg;
    localparam int ROB_W_DEF = 4;

    localparam logic [1:0] KIND_REG  = 2'd0;
    localparam logic [1:0] KIND_BR   = 2'd1;
    localparam logic [1:0] KIND_ST   = 2'd2;
    localparam logic [1:0] KIND_JALR = 2'd3;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/retire, result capture from RS and LSB,
// operand lookup with writeback bypass, and mispredict flush with fetch redirect.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             dc_valid,
    input  logic [1:0]       dc_kind,
    input  logic [4:0]       dc_rd,
    input  logic [31:0]      dc_pc,
    input  logic             dc_pred_taken,
    input  logic [31:0]      dc_alt_pc,
    output logic [ROB_W-1:0] rob_tail_id,
    output logic             rob_full,
    input  logic [ROB_W-1:0] q1_id,
    input  logic [ROB_W-1:0] q2_id,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_val,
    output logic [31:0]      q2_val,
    input  logic             rs_has_output,
    input  logic [ROB_W-1:0] rs_rob_id,
    input  logic [31:0]      rs_output,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_res,
    output logic             cm_valid,
    output logic [ROB_W-1:0] cm_rob_id,
    output logic [4:0]       cm_rd,
    output logic [31:0]      cm_val,
    output logic             cm_store,
    output logic             rob_clear,
    output logic [31:0]      clear_pc
);
    localparam int DEPTH = 1 << ROB_W;
    localparam logic [ROB_W:0] CNT_MAX  = (ROB_W+1)'(DEPTH);
    localparam logic [ROB_W:0] CNT_FULL = (ROB_W+1)'(DEPTH - 1);

    logic [ROB_W-1:0]             r_head, r_tail;
    logic [ROB_W:0]               r_count;
    logic [DEPTH-1:0]             r_busy, r_ready, r_pred;
    logic [DEPTH-1:0][1:0]        r_kind;
    logic [DEPTH-1:0][4:0]        r_rd;
    logic [DEPTH-1:0][31:0]       r_alt, r_val;
    logic                         r_full, r_clear;
    logic [31:0]                  r_clear_pc;
    logic                         r_cm_valid, r_cm_store;
    logic [ROB_W-1:0]             r_cm_rob_id;
    logic [4:0]                   r_cm_rd;
    logic [31:0]                  r_cm_val;

    logic             w_alloc, w_commit, w_mispredict;
    logic [1:0]       w_head_kind;
    logic [ROB_W:0]   w_nx_count;
    logic             w_unused_pc;

    // PC is carried for trace purposes only; nothing in this block consumes it.
    assign w_unused_pc  = ^dc_pc;

    assign w_head_kind  = r_kind[r_head];
    assign w_alloc      = dc_valid & ~r_clear;
    assign w_commit     = ~r_clear & r_busy[r_head] & r_ready[r_head];
    assign w_mispredict = w_commit && (w_head_kind == KIND_BR) &&
                          (r_val[r_head][0] != r_pred[r_head]);
    assign w_nx_count   = r_count + (ROB_W+1)'(w_alloc) - (ROB_W+1)'(w_commit);

    // Lookup priority: stored value, then RS bypass, then LSB bypass.
    always_comb begin
        q1_ready = r_ready[q1_id] | (rs_has_output && rs_rob_id == q1_id) |
                   (lsb_valid && lsb_rob_id == q1_id);
        if (r_ready[q1_id])                          q1_val = r_val[q1_id];
        else if (rs_has_output && rs_rob_id == q1_id) q1_val = rs_output;
        else if (lsb_valid && lsb_rob_id == q1_id)    q1_val = lsb_res;
        else                                          q1_val = '0;

        q2_ready = r_ready[q2_id] | (rs_has_output && rs_rob_id == q2_id) |
                   (lsb_valid && lsb_rob_id == q2_id);
        if (r_ready[q2_id])                          q2_val = r_val[q2_id];
        else if (rs_has_output && rs_rob_id == q2_id) q2_val = rs_output;
        else if (lsb_valid && lsb_rob_id == q2_id)    q2_val = lsb_res;
        else                                          q2_val = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_busy      <= '0;
            r_ready     <= '0;
            r_pred      <= '0;
            r_kind      <= '0;
            r_rd        <= '0;
            r_alt       <= '0;
            r_val       <= '0;
            r_full      <= 1'b0;
            r_clear     <= 1'b0;
            r_clear_pc  <= '0;
            r_cm_valid  <= 1'b0;
            r_cm_store  <= 1'b0;
            r_cm_rob_id <= '0;
            r_cm_rd     <= '0;
            r_cm_val    <= '0;
        end else if (rdy_in) begin
            if (r_clear) begin
                r_busy     <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_full     <= 1'b0;
                r_clear    <= 1'b0;
                r_cm_valid <= 1'b0;
                r_cm_store <= 1'b0;
            end else begin
                r_cm_valid <= w_commit;
                r_cm_store <= w_commit && (w_head_kind == KIND_ST);
                r_clear    <= w_mispredict;
                if (w_commit) begin
                    r_cm_rob_id    <= r_head;
                    r_cm_rd        <= (w_head_kind == KIND_REG || w_head_kind == KIND_JALR) ?
                                      r_rd[r_head] : 5'd0;
                    r_cm_val       <= r_val[r_head];
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + ROB_W'(1);
                end
                if (w_mispredict)
                    r_clear_pc <= r_alt[r_head];
                // LSB is written after RS so it wins on a shared id.
                if (rs_has_output) begin
                    r_ready[rs_rob_id] <= 1'b1;
                    r_val[rs_rob_id]   <= rs_output;
                end
                if (lsb_valid) begin
                    r_ready[lsb_rob_id] <= 1'b1;
                    if (r_kind[lsb_rob_id] != KIND_ST)
                        r_val[lsb_rob_id] <= lsb_res;
                end
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_kind[r_tail]  <= dc_kind;
                    r_rd[r_tail]    <= dc_rd;
                    r_pred[r_tail]  <= dc_pred_taken;
                    r_alt[r_tail]   <= dc_alt_pc;
                    r_tail          <= r_tail + ROB_W'(1);
                end
                r_count <= w_nx_count;
                r_full  <= (w_nx_count >= CNT_FULL);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in && dc_valid && !r_clear)
            assert (r_count != CNT_MAX);
    end

    assign rob_tail_id = r_tail;
    assign rob_full    = r_full;
    assign cm_valid    = r_cm_valid;
    assign cm_rob_id   = r_cm_rob_id;
    assign cm_rd       = r_cm_rd;
    assign cm_val      = r_cm_val;
    assign cm_store    = r_cm_store;
    assign rob_clear   = r_clear;
    assign clear_pc    = r_clear_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based program-order model checked every cycle,
// plus directed scenarios with hand-computed commit sequences.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        dc_valid;
    logic [1:0]  dc_kind;
    logic [4:0]  dc_rd;
    logic [31:0] dc_pc;
    logic        dc_pred_taken;
    logic [31:0] dc_alt_pc;
    logic [3:0]  rob_tail_id;
    logic        rob_full;
    logic [3:0]  q1_id, q2_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        rs_has_output;
    logic [3:0]  rs_rob_id;
    logic [31:0] rs_output;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_res;
    logic        cm_valid;
    logic [3:0]  cm_rob_id;
    logic [4:0]  cm_rd;
    logic [31:0] cm_val;
    logic        cm_store;
    logic        rob_clear;
    logic [31:0] clear_pc;

    reorder_buffer #(.ROB_W(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .dc_valid(dc_valid), .dc_kind(dc_kind), .dc_rd(dc_rd), .dc_pc(dc_pc),
        .dc_pred_taken(dc_pred_taken), .dc_alt_pc(dc_alt_pc),
        .rob_tail_id(rob_tail_id), .rob_full(rob_full),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
        .cm_valid(cm_valid), .cm_rob_id(cm_rob_id), .cm_rd(cm_rd), .cm_val(cm_val),
        .cm_store(cm_store), .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_in) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- model: live entries in program order ----------------
    typedef struct {
        int          id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        bit          rdy;
        bit          vk;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e, m_t;
    int          m_tail = 0;
    bit          m_clear = 0, m_cv = 0, m_cs = 0, m_cvk = 0, m_full = 0;
    int          m_cid = 0;
    logic [4:0]  m_crd = '0;
    logic [31:0] m_cval = '0, m_cpc = '0;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mq.delete(); m_tail = 0; m_clear = 0; m_cpc = '0;
            m_cv = 0; m_cs = 0; m_full = 0;
        end else if (rdy_in) begin
            if (m_clear) begin
                mq.delete(); m_tail = 0; m_clear = 0;
                m_cv = 0; m_cs = 0; m_full = 0;
            end else begin
                m_cv = 0; m_cs = 0;
                if (mq.size() > 0 && mq[0].rdy) begin
                    m_e   = mq.pop_front();
                    m_cv  = 1;
                    m_cid = m_e.id;
                    m_cval = m_e.val;
                    m_cvk = m_e.vk;
                    m_cs  = (m_e.kind == KIND_ST);
                    m_crd = (m_e.kind == KIND_REG || m_e.kind == KIND_JALR) ? m_e.rd : 5'd0;
                    if (m_e.kind == KIND_BR && m_e.val[0] != m_e.pred) begin
                        m_clear = 1;
                        m_cpc   = m_e.alt;
                    end
                end
                foreach (mq[i]) begin
                    m_t = mq[i];
                    if (rs_has_output && int'(rs_rob_id) == m_t.id) begin
                        m_t.rdy = 1; m_t.vk = 1; m_t.val = rs_output;
                    end
                    if (lsb_valid && int'(lsb_rob_id) == m_t.id) begin
                        m_t.rdy = 1;
                        if (m_t.kind != KIND_ST) begin m_t.vk = 1; m_t.val = lsb_res; end
                    end
                    mq[i] = m_t;
                end
                if (dc_valid) begin
                    m_t.id = m_tail; m_t.kind = dc_kind; m_t.rd = dc_rd;
                    m_t.pred = dc_pred_taken; m_t.alt = dc_alt_pc;
                    m_t.rdy = 0; m_t.vk = 0; m_t.val = '0;
                    mq.push_back(m_t);
                    m_tail = (m_tail + 1) % 16;
                end
                m_full = (mq.size() >= 15);
            end
        end
    end

    task automatic chk_q(input string nm, input logic [3:0] id, input logic rdy_a,
                         input logic [31:0] val_a);
        int  idx = -1;
        bit  rsm, lsm, er;
        foreach (mq[i]) if (mq[i].id == int'(id)) idx = i;
        if (idx < 0) return;
        rsm = rs_has_output && rs_rob_id == id;
        lsm = lsb_valid && lsb_rob_id == id;
        er  = mq[idx].rdy || rsm || lsm;
        check({nm, "_ready"}, 32'(rdy_a), 32'(er));
        if (mq[idx].rdy) begin
            if (mq[idx].vk) check({nm, "_val"}, val_a, mq[idx].val);
        end else if (rsm) check({nm, "_val"}, val_a, rs_output);
        else if (lsm)     check({nm, "_val"}, val_a, lsb_res);
    endtask

    typedef struct { int cyc; int id; int rd; logic [31:0] val; bit st; } cm_t;
    cm_t cml[$];

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            check("rob_tail_id", 32'(rob_tail_id), 32'(m_tail));
            check("rob_full", 32'(rob_full), 32'(m_full));
            check("rob_clear", 32'(rob_clear), 32'(m_clear));
            check("cm_valid", 32'(cm_valid), 32'(m_cv));
            check("cm_store", 32'(cm_store), 32'(m_cs));
            if (m_cv) begin
                check("cm_rob_id", 32'(cm_rob_id), 32'(m_cid));
                check("cm_rd", 32'(cm_rd), 32'(m_crd));
                if (m_cvk) check("cm_val", cm_val, m_cval);
            end
            if (m_clear) check("clear_pc", clear_pc, m_cpc);
            chk_q("q1", q1_id, q1_ready, q1_val);
            chk_q("q2", q2_id, q2_ready, q2_val);
            if (cm_valid && rdy_in)
                cml.push_back('{cyc, int'(cm_rob_id), int'(cm_rd), cm_val, cm_store});
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        dc_valid = 0; dc_kind = KIND_REG; dc_rd = '0; dc_pc = '0;
        dc_pred_taken = 0; dc_alt_pc = '0;
        q1_id = '0; q2_id = '0;
        rs_has_output = 0; rs_rob_id = '0; rs_output = '0;
        lsb_valid = 0; lsb_rob_id = '0; lsb_res = '0;
    endtask

    task automatic step();
        @(posedge clk_in); #1;
        set_idle();
    endtask

    task automatic alloc(input logic [1:0] k, input logic [4:0] rd,
                         input logic pred, input logic [31:0] alt);
        dc_valid = 1; dc_kind = k; dc_rd = rd; dc_pred_taken = pred;
        dc_alt_pc = alt; dc_pc = 32'h400 + 32'(rd) * 4;
    endtask

    task automatic rs_wb(input logic [3:0] id, input logic [31:0] v);
        rs_has_output = 1; rs_rob_id = id; rs_output = v;
    endtask

    task automatic lsb_wb(input logic [3:0] id, input logic [31:0] v);
        lsb_valid = 1; lsb_rob_id = id; lsb_res = v;
    endtask

    task automatic do_reset();
        rst_n_in = 0;
        step(); step();
        rst_n_in = 1;
        cml.delete();
    endtask

    initial begin
        logic [1:0] k4;
        set_idle();
        rst_n_in = 0;
        @(posedge clk_in); #1;
        check("reset rob_full", 32'(rob_full), 32'd0);
        check("reset cm_valid", 32'(cm_valid), 32'd0);
        check("reset rob_clear", 32'(rob_clear), 32'd0);
        check("reset tail", 32'(rob_tail_id), 32'd0);
        check("reset clear_pc", clear_pc, 32'd0);
        step();
        rst_n_in = 1;
        cml.delete();

        // in-order retire despite out-of-order writeback
        alloc(KIND_REG, 5, 0, 0); step();
        alloc(KIND_REG, 6, 0, 0); step();
        rs_wb(1, 32'h22); step();
        rs_wb(0, 32'h11); step();
        step(); step(); step();
        check("order count", cml.size(), 2);
        if (cml.size() == 2) begin
            check("order id0", cml[0].id, 0);
            check("order rd0", cml[0].rd, 5);
            check("order val0", cml[0].val, 32'h11);
            check("order id1", cml[1].id, 1);
            check("order rd1", cml[1].rd, 6);
            check("order val1", cml[1].val, 32'h22);
            check("order b2b", cml[1].cyc - cml[0].cyc, 1);
        end

        // stall: rdy_in low freezes allocation
        rdy_in = 0;
        alloc(KIND_REG, 3, 0, 0);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        check("stall tail", 32'(rob_tail_id), 32'd2);
        rdy_in = 1;
        set_idle();
        cml.delete();

        // bypass and RS/LSB priority (head = tail = 2)
        alloc(KIND_REG, 8, 0, 0); step();
        q1_id = 2; rs_wb(2, 32'hDEAD); #1;
        check("bypass rs ready", 32'(q1_ready), 32'd1);
        check("bypass rs val", q1_val, 32'hDEAD);
        step();
        alloc(KIND_JALR, 9, 0, 0); step();
        alloc(KIND_ST, 0, 0, 0); step();
        q2_id = 3; rs_wb(3, 32'h55); lsb_wb(3, 32'h1234); #1;
        check("bypass both ready", 32'(q2_ready), 32'd1);
        check("bypass both val", q2_val, 32'h55);
        step();
        q2_id = 4; lsb_wb(4, 32'h999); #1;
        check("bypass lsb val", q2_val, 32'h999);
        step(); step(); step(); step();
        check("bp count", cml.size(), 3);
        if (cml.size() == 3) begin
            check("bp val2", cml[0].val, 32'hDEAD);
            check("bp jalr rd", cml[1].rd, 9);
            check("bp lsb wins", cml[1].val, 32'h1234);
            check("bp store pulse", 32'(cml[2].st), 32'd1);
            check("bp store rd", cml[2].rd, 0);
        end

        // mispredicted branch flushes younger entries
        do_reset();
        alloc(KIND_BR, 0, 1, 32'h100); step();
        alloc(KIND_REG, 7, 0, 0); rs_wb(0, 32'h0); step();
        alloc(KIND_REG, 8, 0, 0); rs_wb(1, 32'h77); step();
        check("mp rob_clear", 32'(rob_clear), 32'd1);
        check("mp clear_pc", clear_pc, 32'h100);
        check("mp cm_rd", 32'(cm_rd), 32'd0);
        alloc(KIND_REG, 9, 0, 0); rs_wb(2, 32'h88); step();
        check("mp clear pulse", 32'(rob_clear), 32'd0);
        check("mp tail", 32'(rob_tail_id), 32'd0);
        check("mp no commit", 32'(cm_valid), 32'd0);
        step(); step(); step();
        check("mp commits", cml.size(), 1);

        // fill to 15, then retire 17 back-to-back across the wrap
        do_reset();
        for (int k = 0; k < 15; k++) begin
            k4 = (k == 5) ? KIND_ST : (k == 7) ? KIND_JALR : KIND_REG;
            alloc(k4, (k == 9) ? 5'd0 : 5'(k + 1), 0, 0);
            step();
            if (k == 13) check("full at 14", 32'(rob_full), 32'd0);
        end
        check("full at 15", 32'(rob_full), 32'd1);
        check("tail at 15", 32'(rob_tail_id), 32'd15);
        for (int k = 0; k < 18; k++) begin
            if (k <= 16) begin
                if (k == 5) lsb_wb(4'(k), 32'hBEEF);
                else        rs_wb(4'(k % 16), 32'h1000 + 32'(k));
            end
            if (k == 2) alloc(KIND_REG, 20, 0, 0);
            if (k == 3) alloc(KIND_REG, 21, 0, 0);
            step();
        end
        step(); step();
        check("wrap count", cml.size(), 17);
        if (cml.size() == 17) begin
            for (int i = 0; i < 17; i++) begin
                check("wrap id", cml[i].id, i % 16);
                if (i > 0) check("wrap b2b", cml[i].cyc - cml[i-1].cyc, 1);
            end
            check("wrap val0", cml[0].val, 32'h1000);
            check("wrap st", 32'(cml[5].st), 32'd1);
            check("wrap st rd", cml[5].rd, 0);
            check("wrap jalr rd", cml[7].rd, 8);
            check("wrap x0 rd", cml[9].rd, 0);
            check("wrap last rd", cml[16].rd, 21);
            check("wrap last val", cml[16].val, 32'h1010);
        end

        // asynchronous reset mid-cycle while a commit is showing
        do_reset();
        alloc(KIND_REG, 1, 0, 0); step();
        alloc(KIND_REG, 2, 0, 0); rs_wb(0, 32'h5); step();
        alloc(KIND_REG, 3, 0, 0); step();
        check("pre-reset cm_valid", 32'(cm_valid), 32'd1);
        #2 rst_n_in = 0;
        #1;
        check("async cm_valid", 32'(cm_valid), 32'd0);
        check("async rob_full", 32'(rob_full), 32'd0);
        check("async tail", 32'(rob_tail_id), 32'd0);
        step();
        rst_n_in = 1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
